// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// RV32M funct3 opcodes, FSM state encoding and the divide-class helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Every divide/remainder opcode has funct3[2] set.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the unsigned core.
// mode=0: shift-add multiply. acc = {partial product, multiplier}; the
//         multiplicand is added into the upper half when acc[0] is set,
//         then the whole accumulator shifts right by one.
// mode=1: restoring divide. acc = {remainder, dividend/quotient}; the next
//         dividend bit is shifted into the remainder and the divisor is
//         subtracted when it fits. The quotient bit is returned separately
//         and acc_next[0] is left zero for the caller to fill.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              mode,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Combinational single iteration for both modes.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        shifted  = acc[2*XLEN-1:XLEN-1];
        // Remainder stays below the divisor, so a wrap sets diff[XLEN].
        diff     = shifted - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {mul_sum, acc[XLEN-1:1]};
        if (mode) begin
            q_bit    = ~diff[XLEN];
            acc_next = {(diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one operation in flight.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed
// overflow and multiply-by-zero skip the iteration phase.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt_p0;
    logic [2*XLEN-1:0] acc_p0;
    logic [XLEN-1:0]   opnd_p0;
    logic [2:0]        op_p0;
    logic              s1_p0, s2_p0, special_p0;
    logic [XLEN-1:0]   spec_val_p0;
    logic [XLEN-1:0]   res_p1;

    logic              accept, last_iter, early;
    logic              op1_signed, op2_signed, s1, s2;
    logic              div_zero, ovf, special;
    logic [XLEN-1:0]   abs1, abs2, spec_val;
    logic [2*XLEN-1:0] step_acc, acc_upd;
    logic              step_q;

    // Sign-fix the unsigned core result and apply the forced special value.
    function automatic logic [XLEN-1:0] fix_result(
        input logic [2:0]        op,
        input logic [2*XLEN-1:0] fin,
        input logic              sg1,
        input logic              sg2,
        input logic              spc,
        input logic [XLEN-1:0]   spc_val
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rem;
        prod = (sg1 ^ sg2) ? -fin : fin;
        quo  = (sg1 ^ sg2) ? -fin[XLEN-1:0] : fin[XLEN-1:0];
        rem  = sg1 ? -fin[2*XLEN-1:XLEN] : fin[2*XLEN-1:XLEN];
        if (spc)
            return spc_val;
        else if (is_div(op))
            return op[1] ? rem : quo;
        else
            return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_busy   = (state == BUSY) || (state == DONE);
    assign o_result = res_p1;

    assign accept    = (state == IDLE) && i_valid && !i_kill;
    assign last_iter = (cnt_p0 == CNT_W'(XLEN - 1));

    // Accept-time operand decode: signedness, absolute values, special cases.
    always_comb begin
        op1_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
        op2_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        s1         = op1_signed && i_op1[XLEN-1];
        s2         = op2_signed && i_op2[XLEN-1];
        abs1       = s1 ? -i_op1 : i_op1;
        abs2       = s2 ? -i_op2 : i_op2;
        div_zero   = is_div(i_op) && (i_op2 == '0);
        ovf        = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_op1 == MIN_VAL) && (i_op2 == '1);
        spec_val   = '0;
        if (div_zero)
            spec_val = i_op[1] ? i_op1 : '1;
        else if (ovf)
            spec_val = i_op[1] ? '0 : i_op1;
`ifdef MULDIV_EARLY_OUT_EN
        special    = div_zero || ovf || (!is_div(i_op) && ((i_op1 == '0) || (i_op2 == '0)));
        early      = special;
`else
        special    = div_zero || ovf;
        early      = 1'b0;
`endif
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc_p0),
        .operand  (opnd_p0),
        .mode     (is_div(op_p0)),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    assign acc_upd = step_acc | {{(2*XLEN-1){1'b0}}, step_q};

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic; kill always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = early ? DONE : BUSY;
            BUSY:    if (i_kill) state_nxt = IDLE;
                     else if (last_iter) state_nxt = DONE;
            DONE:    if (i_kill || i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, per-cycle iteration and final result register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_p0      <= '0;
            acc_p0      <= '0;
            opnd_p0     <= '0;
            op_p0       <= '0;
            s1_p0       <= 1'b0;
            s2_p0       <= 1'b0;
            special_p0  <= 1'b0;
            spec_val_p0 <= '0;
            res_p1      <= '0;
        end else if (accept) begin
            cnt_p0      <= '0;
            acc_p0      <= {{XLEN{1'b0}}, (is_div(i_op) ? abs1 : abs2)};
            opnd_p0     <= is_div(i_op) ? abs2 : abs1;
            op_p0       <= i_op;
            s1_p0       <= s1;
            s2_p0       <= s2;
            special_p0  <= special;
            spec_val_p0 <= spec_val;
            if (early) res_p1 <= spec_val;
        end else if ((state == BUSY) && !i_kill) begin
            cnt_p0 <= cnt_p0 + 1'b1;
            acc_p0 <= acc_upd;
            if (last_iter)
                res_p1 <= fix_result(op_p0, acc_upd, s1_p0, s2_p0, special_p0, spec_val_p0);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [2:0]      i_op = 3'b000;
    logic [XLEN-1:0] i_op1 = '0;
    logic [XLEN-1:0] i_op2 = '0;
    logic            i_kill = 1'b0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    logic [XLEN-1:0] o_result;
    logic            o_busy;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_kill   (i_kill),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request for a single edge; waits (bounded) for o_ready.
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int w = 0;
        while (!o_ready && w < 100) begin
            tick();
            w++;
        end
        i_valid = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        tick();
        i_valid = 1'b0;
    endtask

    // Issue, wait for o_valid counting cycles from the accept edge (= cycle 0).
    task automatic wait_result(output int lat, output logic [XLEN-1:0] res);
        lat = 1;
        while (!o_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = o_result;
    endtask

    task automatic do_vec(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
        int lat;
        logic [XLEN-1:0] res;
        issue(op, a, b);
        wait_result(lat, res);
        check({tag, "_res"}, 64'(res), 64'(exp));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        tick();
        check({tag, "_vld_drop"}, 64'(o_valid), 64'd0);
        check({tag, "_rdy_back"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int rises;
        logic [XLEN-1:0] res;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // Main function
        do_vec("mul_7xm3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT);
        do_vec("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, FULL_LAT);
        do_vec("mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
        do_vec("mulhsu_m1",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT);
        do_vec("mulh_m2x3",     3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, FULL_LAT);
        do_vec("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, FULL_LAT);
        do_vec("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, FULL_LAT);
        do_vec("divu_big_2",    3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, FULL_LAT);
        do_vec("div_7_m2",      3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
        do_vec("rem_7_m2",      3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, FULL_LAT);
        do_vec("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         FULL_LAT);

        // Divide by zero, signed overflow, zero multiply
        do_vec("divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, SPEC_LAT);
        do_vec("rem_5_0",       3'b110, 32'd5,         32'd0,         32'd5,         SPEC_LAT);
        do_vec("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
        do_vec("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT);
        do_vec("mul_zero",      3'b000, 32'd0,         32'd5,         32'd0,         SPEC_LAT);

        // Backpressure: result held, no accept, ready only after transfer
        i_ready = 1'b0;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(lat, res);
        check("bp_lat", 64'(lat), 64'(FULL_LAT));
        check("bp_res", 64'(res), 64'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_op    = 3'b000;
            i_op1   = 32'd3;
            i_op2   = 32'd4;
            tick();
            check("bp_hold_res", 64'(o_result), 64'hFFFF_FFFE);
            check("bp_hold_rdy", 64'(o_ready), 64'd0);
            check("bp_hold_vld", 64'(o_valid), 64'd1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("bp_rdy_after", 64'(o_ready), 64'd1);
        check("bp_vld_after", 64'(o_valid), 64'd0);
        check("bp_no_accept", 64'(o_busy), 64'd0);

        // Kill in BUSY cycle 10
        issue(3'b101, 32'd1000, 32'd3);
        for (int i = 1; i < 10; i++) tick();
        check("kill_busy_before", 64'(o_busy), 64'd1);
        i_kill = 1'b1;
        tick();
        i_kill = 1'b0;
        check("kill_rdy", 64'(o_ready), 64'd1);
        check("kill_busy", 64'(o_busy), 64'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid) rises++;
            tick();
        end
        check("kill_no_valid", 64'(rises), 64'd0);
        check("kill_res_kept", 64'(o_result), 64'hFFFF_FFFE);

        // Kill beats valid in IDLE
        i_valid = 1'b1;
        i_kill  = 1'b1;
        i_op    = 3'b000;
        i_op1   = 32'd2;
        i_op2   = 32'd2;
        tick();
        i_valid = 1'b0;
        i_kill  = 1'b0;
        check("idle_kill_busy", 64'(o_busy), 64'd0);
        check("idle_kill_rdy", 64'(o_ready), 64'd1);

        // Reset mid-op in BUSY cycle 20
        issue(3'b000, 32'd9, 32'd9);
        for (int i = 1; i < 20; i++) tick();
        i_rst_n = 1'b0;
        tick();
        check("mrst_valid", 64'(o_valid), 64'd0);
        check("mrst_result", 64'(o_result), 64'd0);
        check("mrst_ready", 64'(o_ready), 64'd1);
        check("mrst_busy", 64'(o_busy), 64'd0);
        i_rst_n = 1'b1;
        tick();
        do_vec("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, FULL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit, the parametrised multi-cycle companion to the single-cycle ALU in the execute stage.
- Implements the RV32M operation set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over XLEN-bit operands.
- Radix-2 shift-add multiply and restoring divide; one operation in flight.
- Valid/ready handshake on input and output, plus a kill input for pipeline squash.

Parameters:
- XLEN, 32, operand/result width; legal values are 4..64, even.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, never overridden.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept; high only in IDLE.
- i_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_op1  input  XLEN  rs1 / dividend / multiplicand.
- i_op2  input  XLEN  rs2 / divisor / multiplier.
- i_kill  input  1  abort current or offered operation.
- o_valid  output  1  result valid; high only in DONE.
- i_ready  input  1  consumer accepts the result.
- o_result  output  XLEN  result, held stable while o_valid=1 and i_ready=0.
- o_busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (i_rst_n=0 at an edge): state becomes IDLE; o_valid=0, o_ready=1 after the edge, o_result=0, o_busy=0; counter and datapath registers cleared. Reset at any point aborts the in-flight op.
- FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY: on i_valid & o_ready & ~i_kill. Operands, op, sign flags and counter=0 are latched at that edge.
- BUSY: one radix-2 iteration per cycle.
  - After iteration XLEN-1 the result is sign-fixed, registered into o_result, and the FSM moves to DONE.
  - Latency: accept edge is cycle 0; o_valid rises in cycle XLEN+1 (33 at XLEN=32).
- DONE to IDLE: on i_ready. o_valid and i_ready high in the same cycle completes the transfer; o_ready is high the next cycle.
- No accept occurs in DONE; back-to-back issue costs one IDLE cycle.
- Kill:
  - i_kill in IDLE blocks acceptance, and kill wins over i_valid.
  - i_kill in BUSY or DONE forces IDLE next edge; o_valid drops without a transfer, and o_result is not updated.
- Signed handling:
  - MULH: both operands are signed.
  - MULHSU: op1 is signed, op2 is unsigned.
  - DIV/REM: both operands are signed.
  - Absolute values are latched; the unsigned core operates on them.
  - The 2XLEN product is negated when the operand signs differ.
  - The quotient is negated when the signs differ and the divisor is nonzero; the remainder takes the dividend's sign.
- Result select:
  - MUL takes product[XLEN-1:0]; MULH* takes product[2XLEN-1:XLEN].
  - DIV/DIVU takes the quotient; REM/REMU takes the remainder.
  - Carry out beyond 2XLEN is discarded.
- Special cases, detected at accept and forced at result time:
  - Divide by zero: quotient = all ones, remainder = op1.
  - Signed overflow (op1 = 1<<(XLEN-1), op2 = all ones): DIV gives op1, REM gives 0.
- Inputs are ignored while o_ready=0, and i_ready is ignored outside DONE.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined:
  - Divide-by-zero and signed-overflow cases skip BUSY and go IDLE to DONE directly, so o_valid is high in cycle 1.
  - A multiply with either operand zero also goes directly to DONE with result 0.
- Undefined: all operations take the full XLEN+1 latency, and results are identical.

Decomposition:
- Package muldiv_pkg holds:
  - localparams for the eight funct3 opcodes;
  - the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - an is_div(op) helper function.
- One sub-module, muldiv_step: the combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator and next quotient bit.
  - Instantiated once; the FSM, counter and sign fix stay in muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD at XLEN=32, i_ready=1: o_result=0xFFFFFFEB, o_valid in cycle 33 for exactly 1 cycle. MULH 0x80000000 x 0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF: 0xFFFFFFFF. DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD. REM 0xFFFFFFF9 / 2 gives 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 gives 0x7FFFFFFC.
- Divide by zero and overflow:
  - DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
  - o_valid appears in cycle 33 with the macro undefined and in cycle 1 with it defined.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid. o_result stays stable, o_ready stays 0, and a new i_valid is ignored. Raising i_ready gives o_ready=1 next cycle.
- Kill: assert i_kill in BUSY cycle 10. o_valid never rises and o_ready=1 next cycle. i_valid with i_kill in IDLE: no accept, o_busy stays 0.
- Reset mid-op: drop i_rst_n in BUSY cycle 20. After the edge o_valid=0, o_result=0, o_ready=1. The next op, DIVU 100/7, returns 14.
